// File: rtl/trigger_unit.sv
// Debug trigger unit: a bank of address-match triggers (mcontrol style)
// reachable through CSR accesses and debugger register accesses, reporting
// the lowest-index firing trigger as a one-cycle hit pulse.
module trigger_unit #(
    parameter int NUM_TRIG   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic [11:0]           csr_addr,
    input  logic                  csr_rd,
    input  logic                  csr_wr,
    input  logic [1:0]            csr_op,
    input  logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic                  dbg_mode,
    input  logic                  dbg_reg_access,
    input  logic                  dbg_wr1_rd0,
    input  logic [15:0]           dbg_regno,
    input  logic [DATA_WIDTH-1:0] dbg_write_data,
    input  logic                  exec_valid,
    input  logic [DATA_WIDTH-1:0] exec_pc,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_addr,
    input  logic                  st_valid,
    input  logic [DATA_WIDTH-1:0] st_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  trig_hit,
    output logic                  trig_action,
    output logic [3:0]            trig_index
);

    localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
    localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
    localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;
    localparam logic [11:0] ADDR_TINFO   = 12'h7A4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    // Compare an access address against a trigger's tdata2 using its match mode.
    function automatic logic addrCompare(input logic [1:0] mode,
                                         input logic [DATA_WIDTH-1:0] addr,
                                         input logic [DATA_WIDTH-1:0] cmpVal);
        logic result;
        case (mode)
            2'd0:    result = (addr == cmpVal);
            2'd2:    result = (addr >= cmpVal);
            2'd3:    result = (addr < cmpVal);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // Architectural state
    logic [3:0]            tselect_q, tselect_d;
    logic [NUM_TRIG-1:0]   dmode_q, dmode_d;
    logic [NUM_TRIG-1:0]   hitb_q, hitb_d;
    logic [NUM_TRIG-1:0]   action_q, action_d;
    logic [NUM_TRIG-1:0]   m_q, m_d;
    logic [NUM_TRIG-1:0]   exec_q, exec_d;
    logic [NUM_TRIG-1:0]   store_q, store_d;
    logic [NUM_TRIG-1:0]   load_q, load_d;
    logic [1:0]            match_q [NUM_TRIG];
    logic [1:0]            match_d [NUM_TRIG];
    logic [DATA_WIDTH-1:0] tdata2_q [NUM_TRIG];
    logic [DATA_WIDTH-1:0] tdata2_d [NUM_TRIG];

    // Output registers
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  trig_hit_q, trig_hit_d;
    logic                  trig_action_q, trig_action_d;
    logic [3:0]            trig_index_q, trig_index_d;

    // Resolved access
    logic                  accFromDbg;
    logic                  accRd;
    logic                  accWr;
    logic [11:0]           accAddr;
    logic [1:0]            accOp;
    logic [DATA_WIDTH-1:0] accWdata;

    logic [NUM_TRIG-1:0]   selVec;
    logic [31:0]           curTdata1;
    logic [DATA_WIDTH-1:0] curTdata2;
    logic                  selDmode;
    logic [DATA_WIDTH-1:0] curVal;
    logic [DATA_WIDTH-1:0] rdVal;
    logic [DATA_WIDTH-1:0] newVal;
    logic                  wrEn;
    logic                  wrTselect;
    logic                  wrTdata1;
    logic                  wrTdata2;
    logic [NUM_TRIG-1:0]   fire;

    // Pick the winning access: an in-range debugger access replaces any CSR access.
    always_comb begin
        accFromDbg = dbg_reg_access && (dbg_regno[15:12] == 4'h0);
        if (accFromDbg) begin
            accAddr  = dbg_regno[11:0];
            accRd    = !dbg_wr1_rd0;
            accWr    = dbg_wr1_rd0;
            accOp    = OP_WRITE;
            accWdata = dbg_write_data;
        end else begin
            accAddr  = csr_addr;
            accRd    = csr_rd;
            accWr    = csr_wr;
            accOp    = csr_op;
            accWdata = csr_wdata;
        end
    end

    // Current register values of the selected trigger, read data and write data.
    always_comb begin
        curTdata1 = 32'h0;
        curTdata2 = '0;
        selDmode  = 1'b0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            selVec[i] = (tselect_q == 4'(i));
            if (selVec[i]) begin
                curTdata1 = {4'h2, dmode_q[i], 6'b0, hitb_q[i], 4'b0,
                             3'b0, action_q[i], 1'b0, 2'b0, match_q[i],
                             m_q[i], 3'b0, exec_q[i], store_q[i], load_q[i]};
                curTdata2 = tdata2_q[i];
                selDmode  = dmode_q[i];
            end
        end

        case (accAddr)
            ADDR_TSELECT: curVal = DATA_WIDTH'(tselect_q);
            ADDR_TDATA1:  curVal = DATA_WIDTH'(curTdata1);
            ADDR_TDATA2:  curVal = curTdata2;
            default:      curVal = '0;
        endcase
        rdVal = (accAddr == ADDR_TINFO) ? DATA_WIDTH'(32'h4) : curVal;

        case (accOp)
            OP_SET:   newVal = curVal | accWdata;
            OP_CLEAR: newVal = curVal & ~accWdata;
            default:  newVal = accWdata;
        endcase

        // A dmode trigger is only writable from debug mode or by the debugger.
        wrEn      = accWr && (accOp != 2'b11);
        wrTselect = wrEn && (accAddr == ADDR_TSELECT);
        wrTdata1  = wrEn && (accAddr == ADDR_TDATA1) && !(selDmode && !dbg_mode && !accFromDbg);
        wrTdata2  = wrEn && (accAddr == ADDR_TDATA2) && !(selDmode && !dbg_mode && !accFromDbg);
    end

    // Evaluate every trigger against the three match sources this cycle.
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            fire[i] = m_q[i] && !dbg_mode &&
                      ((exec_q[i]  && exec_valid && addrCompare(match_q[i], exec_pc, tdata2_q[i])) ||
                       (load_q[i]  && ld_valid   && addrCompare(match_q[i], ld_addr, tdata2_q[i])) ||
                       (store_q[i] && st_valid   && addrCompare(match_q[i], st_addr, tdata2_q[i])));
        end
    end

    // Next-state for the register file: legalised writes win over hit updates.
    always_comb begin
        tselect_d = tselect_q;
        if (wrTselect && (newVal < DATA_WIDTH'(NUM_TRIG))) begin
            tselect_d = newVal[3:0];
        end
        dmode_d  = dmode_q;
        hitb_d   = hitb_q;
        action_d = action_q;
        m_d      = m_q;
        exec_d   = exec_q;
        store_d  = store_q;
        load_d   = load_q;
        for (int i = 0; i < NUM_TRIG; i++) begin
            match_d[i]  = match_q[i];
            tdata2_d[i] = tdata2_q[i];
            if (wrTdata1 && selVec[i]) begin
                dmode_d[i]  = newVal[27];
                hitb_d[i]   = newVal[20];
                action_d[i] = newVal[27] && (newVal[15:12] == 4'h1);
                case (newVal[10:7])
                    4'd2:    match_d[i] = 2'd2;
                    4'd3:    match_d[i] = 2'd3;
                    default: match_d[i] = 2'd0;
                endcase
                m_d[i]     = newVal[6];
                exec_d[i]  = newVal[2];
                store_d[i] = newVal[1];
                load_d[i]  = newVal[0];
            end else if (fire[i]) begin
                hitb_d[i] = 1'b1;
            end
            if (wrTdata2 && selVec[i]) begin
                tdata2_d[i] = newVal;
            end
        end
    end

    // Next-state for the read port and the hit report (lowest index wins).
    always_comb begin
        rd_valid_d    = accRd;
        rd_data_d     = accRd ? rdVal : rd_data_q;
        trig_hit_d    = |fire;
        trig_index_d  = 4'h0;
        trig_action_d = 1'b0;
        for (int i = NUM_TRIG - 1; i >= 0; i--) begin
            if (fire[i]) begin
                trig_index_d  = 4'(i);
                trig_action_d = action_q[i];
            end
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            tselect_q     <= '0;
            dmode_q       <= '0;
            hitb_q        <= '0;
            action_q      <= '0;
            m_q           <= '0;
            exec_q        <= '0;
            store_q       <= '0;
            load_q        <= '0;
            for (int i = 0; i < NUM_TRIG; i++) begin
                match_q[i]  <= '0;
                tdata2_q[i] <= '0;
            end
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            trig_hit_q    <= 1'b0;
            trig_action_q <= 1'b0;
            trig_index_q  <= 4'h0;
        end else begin
            tselect_q     <= tselect_d;
            dmode_q       <= dmode_d;
            hitb_q        <= hitb_d;
            action_q      <= action_d;
            m_q           <= m_d;
            exec_q        <= exec_d;
            store_q       <= store_d;
            load_q        <= load_d;
            for (int i = 0; i < NUM_TRIG; i++) begin
                match_q[i]  <= match_d[i];
                tdata2_q[i] <= tdata2_d[i];
            end
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            trig_hit_q    <= trig_hit_d;
            trig_action_q <= trig_action_d;
            trig_index_q  <= trig_index_d;
        end
    end

    // A hit pulse already registered is suppressed while reset is asserted.
    assign trig_hit    = trig_hit_q && !cpu_rst;
    assign trig_action = trig_action_q && !cpu_rst;
    assign trig_index  = cpu_rst ? 4'h0 : trig_index_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_trigger_unit.sv
// Self-checking bench for trigger_unit: expected read data and hit reports
// are queued as stimulus is driven and compared when the DUT responds.
module tb_trigger_unit;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [11:0] csr_addr;
    logic        csr_rd, csr_wr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        dbg_mode, dbg_reg_access, dbg_wr1_rd0;
    logic [15:0] dbg_regno;
    logic [31:0] dbg_write_data;
    logic        exec_valid, ld_valid, st_valid;
    logic [31:0] exec_pc, ld_addr, st_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        trig_hit, trig_action;
    logic [3:0]  trig_index;

    typedef struct packed {
        logic       hit;
        logic       act;
        logic [3:0] idx;
    } hitExp_t;

    logic [31:0] rdQ[$];
    hitExp_t     hitQ[$];
    int          checks = 0;
    int          errors = 0;

    trigger_unit #(.NUM_TRIG(4), .DATA_WIDTH(32)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .csr_addr(csr_addr), .csr_rd(csr_rd), .csr_wr(csr_wr),
        .csr_op(csr_op), .csr_wdata(csr_wdata),
        .dbg_mode(dbg_mode), .dbg_reg_access(dbg_reg_access),
        .dbg_wr1_rd0(dbg_wr1_rd0), .dbg_regno(dbg_regno),
        .dbg_write_data(dbg_write_data),
        .exec_valid(exec_valid), .exec_pc(exec_pc),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .st_valid(st_valid), .st_addr(st_addr),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .trig_hit(trig_hit), .trig_action(trig_action), .trig_index(trig_index)
    );

    // Free-running clock
    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic applyStimulus();
        csr_rd = 0; csr_wr = 0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 0;
        dbg_reg_access = 0; dbg_wr1_rd0 = 0; dbg_regno = 16'h0; dbg_write_data = 0;
        exec_valid = 0; ld_valid = 0; st_valid = 0;
        exec_pc = 0; ld_addr = 0; st_addr = 0;
    endtask

    task automatic csrWrite(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_addr = a; csr_op = op; csr_wdata = d; csr_wr = 1;
        tick();
        csr_wr = 0;
    endtask

    task automatic csrRead(input logic [11:0] a);
        csr_addr = a; csr_rd = 1;
        tick();
        csr_rd = 0;
    endtask

    task automatic dbgWrite(input logic [15:0] r, input logic [31:0] d);
        dbg_regno = r; dbg_write_data = d; dbg_wr1_rd0 = 1; dbg_reg_access = 1;
        tick();
        dbg_reg_access = 0;
    endtask

    task automatic dbgRead(input logic [15:0] r);
        dbg_regno = r; dbg_wr1_rd0 = 0; dbg_reg_access = 1;
        tick();
        dbg_reg_access = 0;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [6] = '{12'h7A0, 12'h7A1, 12'h7A2, 12'h7A3, 12'h7A4, 12'h123};
        logic [31:0] exps  [6] = '{32'h0, 32'h2000_0000, 32'h0, 32'h0, 32'h4, 32'h0};
        logic [31:0] e;
        cpu_rst = 1;
        tick(); tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0 || trig_hit !== 1'b0 ||
            trig_action !== 1'b0 || trig_index !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b d=%h h=%b a=%b i=%h, expected all zero",
                     rd_valid, rd_data, trig_hit, trig_action, trig_index);
        end
        cpu_rst = 0;
        for (int i = 0; i < 6; i++) begin
            rdQ.push_back(exps[i]);
            csrRead(addrs[i]);
            e = rdQ.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                errors++;
                $display("[TB] FAIL reset_read_%h: got v=%b d=%h, expected v=1 d=%h", addrs[i], rd_valid, rd_data, e);
            end
        end
    endtask

    task automatic test_tselect_warl();
        logic [31:0] wv [4] = '{32'h5, 32'h2, 32'h1, 32'h4};
        logic [1:0]  op [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic [31:0] ex [4] = '{32'h0, 32'h2, 32'h3, 32'h3};
        logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            csrWrite(12'h7A0, op[i], wv[i]);
            rdQ.push_back(ex[i]);
            csrRead(12'h7A0);
            e = rdQ.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                errors++;
                $display("[TB] FAIL tselect_%0d: got v=%b d=%h, expected v=1 d=%h", i, rd_valid, rd_data, e);
            end
        end
    endtask

    task automatic test_exec_hit();
        logic [31:0] e;
        hitExp_t h;
        csrWrite(12'h7A0, 2'b00, 32'h1);
        csrWrite(12'h7A1, 2'b00, 32'h0000_0044);
        csrWrite(12'h7A2, 2'b00, 32'h8000_0100);
        rdQ.push_back(32'h2000_0044);
        csrRead(12'h7A1);
        e = rdQ.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("[TB] FAIL exec_cfg: got d=%h, expected %h", rd_data, e);
        end
        // miss, hit, then the pulse must drop
        hitQ.push_back('{hit: 1'b0, act: 1'b0, idx: 4'h0});
        hitQ.push_back('{hit: 1'b1, act: 1'b0, idx: 4'h1});
        hitQ.push_back('{hit: 1'b0, act: 1'b0, idx: 4'h0});
        for (int k = 0; k < 3; k++) begin
            exec_valid = (k < 2);
            exec_pc = (k == 0) ? 32'h8000_0104 : 32'h8000_0100;
            tick();
            h = hitQ.pop_front();
            checks++;
            if (trig_hit !== h.hit || (h.hit && (trig_index !== h.idx || trig_action !== h.act))) begin
                errors++;
                $display("[TB] FAIL exec_hit_%0d: got h=%b i=%h a=%b, expected h=%b i=%h a=%b",
                         k, trig_hit, trig_index, trig_action, h.hit, h.idx, h.act);
            end
        end
        exec_valid = 0;
        rdQ.push_back(32'h2010_0044);
        csrRead(12'h7A1);
        e = rdQ.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("[TB] FAIL exec_hitbit: got d=%h, expected %h", rd_data, e);
        end
    endtask

    task automatic test_dmode_lock();
        logic [31:0] e;
        csrWrite(12'h7A0, 2'b00, 32'h3);
        csrWrite(12'h7A1, 2'b00, 32'h0000_1044);
        rdQ.push_back(32'h2000_0044);
        csrRead(12'h7A1);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL action_no_dmode: got %h, expected %h", rd_data, e); end
        dbgWrite(16'h07A1, 32'h0800_1044);
        rdQ.push_back(32'h2800_1044);
        csrRead(12'h7A1);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL dbg_write_dmode: got %h, expected %h", rd_data, e); end
        csrWrite(12'h7A1, 2'b00, 32'h0000_0044);
        csrWrite(12'h7A2, 2'b00, 32'h0000_0055);
        rdQ.push_back(32'h2800_1044);
        rdQ.push_back(32'h0);
        csrRead(12'h7A1);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL locked_tdata1: got %h, expected %h", rd_data, e); end
        csrRead(12'h7A2);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL locked_tdata2: got %h, expected %h", rd_data, e); end
        dbg_mode = 1;
        csrWrite(12'h7A2, 2'b00, 32'h0000_0055);
        dbg_mode = 0;
        rdQ.push_back(32'h0000_0055);
        dbgRead(16'h07A2);
        e = rdQ.pop_front(); checks++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++; $display("[TB] FAIL dbgmode_tdata2: got v=%b d=%h, expected %h", rd_valid, rd_data, e);
        end
        exec_valid = 1; exec_pc = 32'h55;
        hitQ.push_back('{hit: 1'b1, act: 1'b1, idx: 4'h3});
        tick();
        exec_valid = 0;
        begin
            hitExp_t h;
            h = hitQ.pop_front(); checks++;
            if (trig_hit !== h.hit || trig_index !== h.idx || trig_action !== h.act) begin
                errors++;
                $display("[TB] FAIL debug_action: got h=%b i=%h a=%b, expected h=%b i=%h a=%b",
                         trig_hit, trig_index, trig_action, h.hit, h.idx, h.act);
            end
        end
    endtask

    task automatic test_multi_load();
        logic [31:0] e;
        hitExp_t h;
        csrWrite(12'h7A0, 2'b00, 32'h0);
        csrWrite(12'h7A1, 2'b00, 32'h41);
        csrWrite(12'h7A2, 2'b00, 32'h1000);
        csrWrite(12'h7A0, 2'b00, 32'h2);
        csrWrite(12'h7A1, 2'b00, 32'h41);
        csrWrite(12'h7A2, 2'b00, 32'h1000);
        hitQ.push_back('{hit: 1'b0, act: 1'b0, idx: 4'h0});
        hitQ.push_back('{hit: 1'b1, act: 1'b0, idx: 4'h0});
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1; ld_addr = (k == 0) ? 32'h1001 : 32'h1000;
            tick();
            h = hitQ.pop_front(); checks++;
            if (trig_hit !== h.hit || (h.hit && (trig_index !== h.idx || trig_action !== h.act))) begin
                errors++;
                $display("[TB] FAIL load_hit_%0d: got h=%b i=%h a=%b, expected h=%b i=%h a=%b",
                         k, trig_hit, trig_index, trig_action, h.hit, h.idx, h.act);
            end
        end
        ld_valid = 0;
        rdQ.push_back(32'h2010_0041);
        csrRead(12'h7A1);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL load_hitbit_t2: got %h, expected %h", rd_data, e); end
        csrWrite(12'h7A0, 2'b00, 32'h0);
        rdQ.push_back(32'h2010_0041);
        csrRead(12'h7A1);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL load_hitbit_t0: got %h, expected %h", rd_data, e); end
    endtask

    task automatic test_store_match();
        logic [31:0] e;
        hitExp_t h;
        csrWrite(12'h7A0, 2'b00, 32'h2);
        csrWrite(12'h7A1, 2'b00, 32'h0000_00C2);
        rdQ.push_back(32'h2000_0042);
        csrRead(12'h7A1);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL illegal_match: got %h, expected %h", rd_data, e); end
        csrWrite(12'h7A1, 2'b01, 32'h0000_0180);
        csrWrite(12'h7A2, 2'b00, 32'h2000);
        rdQ.push_back(32'h2000_01C2);
        csrRead(12'h7A1);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL set_match: got %h, expected %h", rd_data, e); end
        // 0x1FFF < 0x2000 hits, 0x2000 misses, debug mode suppresses
        hitQ.push_back('{hit: 1'b1, act: 1'b0, idx: 4'h2});
        hitQ.push_back('{hit: 1'b0, act: 1'b0, idx: 4'h0});
        hitQ.push_back('{hit: 1'b0, act: 1'b0, idx: 4'h0});
        for (int k = 0; k < 3; k++) begin
            st_valid = 1;
            st_addr = (k == 1) ? 32'h2000 : 32'h1FFF;
            dbg_mode = (k == 2);
            tick();
            h = hitQ.pop_front(); checks++;
            if (trig_hit !== h.hit || (h.hit && (trig_index !== h.idx || trig_action !== h.act))) begin
                errors++;
                $display("[TB] FAIL store_hit_%0d: got h=%b i=%h a=%b, expected h=%b i=%h a=%b",
                         k, trig_hit, trig_index, trig_action, h.hit, h.idx, h.act);
            end
        end
        st_valid = 0; dbg_mode = 0;
        csrWrite(12'h7A1, 2'b10, 32'h0000_0100);
        rdQ.push_back(32'h2010_0042);
        csrRead(12'h7A1);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL clear_match: got %h, expected %h", rd_data, e); end
        csrWrite(12'h7A1, 2'b00, 32'h0000_01C2);
    endtask

    task automatic test_write_wins();
        logic [31:0] e;
        st_valid = 1; st_addr = 32'h1FFF;
        hitQ.push_back('{hit: 1'b1, act: 1'b0, idx: 4'h2});
        csrWrite(12'h7A1, 2'b00, 32'h0000_01C2);
        st_valid = 0;
        begin
            hitExp_t h;
            h = hitQ.pop_front(); checks++;
            if (trig_hit !== h.hit || trig_index !== h.idx) begin
                errors++;
                $display("[TB] FAIL wins_pulse: got h=%b i=%h, expected h=%b i=%h", trig_hit, trig_index, h.hit, h.idx);
            end
        end
        rdQ.push_back(32'h2000_01C2);
        csrRead(12'h7A1);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL wins_hitbit: got %h, expected %h", rd_data, e); end
    endtask

    task automatic test_priority();
        logic [31:0] e;
        csr_rd = 1; csr_wr = 1; csr_addr = 12'h7A2; csr_op = 2'b00; csr_wdata = 32'h3000;
        rdQ.push_back(32'h2000);
        tick();
        csr_rd = 0; csr_wr = 0;
        e = rdQ.pop_front(); checks++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++; $display("[TB] FAIL read_old: got v=%b d=%h, expected %h", rd_valid, rd_data, e);
        end
        rdQ.push_back(32'h3000);
        csrRead(12'h7A2);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL read_new: got %h, expected %h", rd_data, e); end
        dbg_regno = 16'h07A0; dbg_write_data = 32'h0; dbg_wr1_rd0 = 1; dbg_reg_access = 1;
        csrWrite(12'h7A0, 2'b00, 32'h1);
        dbg_reg_access = 0;
        rdQ.push_back(32'h0);
        csrRead(12'h7A0);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL dbg_priority: got %h, expected %h", rd_data, e); end
        dbg_regno = 16'h1000; dbg_write_data = 32'h0; dbg_wr1_rd0 = 1; dbg_reg_access = 1;
        csrWrite(12'h7A0, 2'b00, 32'h3);
        dbg_reg_access = 0;
        rdQ.push_back(32'h3);
        csrRead(12'h7A0);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL dbg_out_of_range: got %h, expected %h", rd_data, e); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] addrs [4] = '{12'h7A4, 12'h7A0, 12'h123, 12'h7A3};
        logic [31:0] exps  [4] = '{32'h4, 32'h3, 32'h0, 32'h0};
        logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            rdQ.push_back(exps[i]);
            csr_addr = addrs[i]; csr_rd = 1;
            tick();
            e = rdQ.pop_front(); checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                errors++;
                $display("[TB] FAIL b2b_%0d: got v=%b d=%h, expected v=1 d=%h", i, rd_valid, rd_data, e);
            end
        end
        csr_rd = 0;
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_valid_drop: got %b, expected 0", rd_valid); end
    endtask

    task automatic test_reset_hit();
        logic [31:0] e;
        csrWrite(12'h7A0, 2'b00, 32'h2);
        st_valid = 1; st_addr = 32'h2FFF;
        tick();
        st_valid = 0;
        checks++;
        if (trig_hit !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_hit: got %b, expected 1", trig_hit); end
        cpu_rst = 1;
        #1;
        checks++;
        if (trig_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_drops_pulse: got %b, expected 0", trig_hit); end
        st_valid = 1;
        csrWrite(12'h7A0, 2'b00, 32'h1);
        st_valid = 0;
        cpu_rst = 0;
        tick();
        checks++;
        if (trig_hit !== 1'b0 || trig_index !== 4'h0 || trig_action !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_out: got h=%b i=%h a=%b v=%b, expected zeros",
                     trig_hit, trig_index, trig_action, rd_valid);
        end
        rdQ.push_back(32'h0);
        rdQ.push_back(32'h2000_0000);
        csrRead(12'h7A0);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL post_reset_tselect: got %h, expected %h", rd_data, e); end
        csrWrite(12'h7A0, 2'b00, 32'h2);
        csrRead(12'h7A1);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL post_reset_tdata1: got %h, expected %h", rd_data, e); end
        rdQ.push_back(32'h0);
        csrRead(12'h7A2);
        e = rdQ.pop_front(); checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL post_reset_tdata2: got %h, expected %h", rd_data, e); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        cpu_rst = 1;
        dbg_mode = 0;
        applyStimulus();
        test_reset();
        test_tselect_warl();
        test_exec_hit();
        test_dmode_lock();
        test_multi_load();
        test_store_match();
        test_write_wins();
        test_priority();
        test_back_to_back();
        test_reset_hit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trigger_unit.md
TRIGGER_UNIT -- requirements
Module: trigger_unit

Interface
REQ-001 Parameter: NUM_TRIG, default 4, number of triggers (1..16).
REQ-002 Parameter: DATA_WIDTH, default 32, data/address width.
REQ-003 cpu_clk  input  1  single clock; all state on rising edge.
REQ-004 cpu_rst  input  1  synchronous, active-high reset.
REQ-005 csr_addr  input  12  CSR address.
REQ-006 csr_rd, csr_wr  input  1 each  CSR read/write strobe.
REQ-007 csr_op  input  2  00 write, 01 set, 10 clear.
REQ-008 csr_wdata  input  DATA_WIDTH  CSR write data.
REQ-009 dbg_mode  input  1  hart in debug mode.
REQ-010 dbg_reg_access, dbg_wr1_rd0  input  1 each  debugger register access, direction.
REQ-011 dbg_regno  input  16  debugger register number; 0x0000-0x0FFF addresses CSRs.
REQ-012 dbg_write_data  input  DATA_WIDTH  debugger write data.
REQ-013 exec_valid/exec_pc, ld_valid/ld_addr, st_valid/st_addr  input  1/DATA_WIDTH each  match sources.
REQ-014 rd_valid  output  1  read data valid, one cycle after the read strobe.
REQ-015 rd_data  output  DATA_WIDTH  registered read data.
REQ-016 trig_hit  output  1  one-cycle hit pulse.
REQ-017 trig_action  output  1  0 breakpoint exception, 1 enter debug mode.
REQ-018 trig_index  output  4  index of the reported trigger.

Function
REQ-019 Address map: tselect 0x7A0, tdata1 0x7A1, tdata2 0x7A2, tdata3 0x7A3, tinfo 0x7A4; all other addresses read 0 with rd_valid=1.
REQ-020 Debugger access (dbg_reg_access, regno in range) takes priority over a same-cycle CSR access, which is then dropped; a debugger write is always a plain write.
REQ-021 tselect write: values >= NUM_TRIG leave tselect unchanged (WARL).
REQ-022 tdata1 is per-trigger mcontrol: type[31:28] fixed 2, dmode[27], hit[20], action[15:12], match[10:7], m[6], execute[2], store[1], load[0]; all other bits read 0.
REQ-023 action legal values are 0 and 1; action=1 is stored only when the written dmode=1, otherwise action is stored as 0.
REQ-024 match legal values are 0 (equal), 2 (>=), and 3 (<), unsigned; any other written value stores 0.
REQ-025 When the selected trigger has dmode=1, writes to its tdata1/tdata2 are ignored unless dbg_mode=1 or the access comes from the debugger.
REQ-026 tdata2 is per-trigger compare value, full width; tdata3 reads 0 and ignores writes; tinfo reads 0x0000_0004.
REQ-027 Set/clear apply to the current value; legalisation (REQ-021/023/024) is applied to the result.
REQ-028 A trigger fires in cycle N when m=1, dbg_mode=0, and any enabled source (execute/load/store) is valid and its address compares true.
REQ-029 In cycle N+1: trig_hit=1, trig_index = lowest firing index, trig_action = that trigger's action, and the hit bit of every firing trigger is set.
REQ-030 A same-cycle software/debugger write to a firing trigger's tdata1 wins, including the hit bit.
REQ-031 A read in cycle N returns in cycle N+1 the value before any same-cycle write; rd_valid pulses once per read.

Reset
REQ-032 On cpu_rst the following are cleared: tselect=0; all tdata1 read 0x2000_0000; all tdata2=0; rd_valid=0; rd_data=0; trig_hit=0; trig_action=0; trig_index=0.
REQ-033 Reset takes priority over any same-cycle access or match, and drops a pending hit pulse.

Verification
REQ-034 Write tselect=5 with NUM_TRIG=4 -> tselect unchanged; read 0x7A0 returns 0 next cycle.
REQ-035 Trigger 1: tdata1=0x0000_0044, tdata2=0x8000_0100; exec_pc=0x8000_0100 with exec_valid -> next cycle trig_hit=1, trig_index=1, trig_action=0; tdata1 reads 0x2010_0044.
REQ-036 Write tdata1=0x0000_1044 (dmode=0) -> reads 0x2000_0044; write 0x0800_1044 from the debugger -> reads 0x2800_1044; then a CSR write with dbg_mode=0 -> ignored.
REQ-037 Triggers 0 and 2 both load-match 0x1000 in one cycle -> trig_index=0; hit set in both.
REQ-038 match=3, tdata2=0x2000, st_addr=0x1FFF -> hit; st_addr=0x2000 -> no hit; any match with dbg_mode=1 -> no hit.
REQ-039 Assert cpu_rst in the cycle after a match -> trig_hit=0, all registers at reset values.
